mm_io_responder: RTL and testbench
==================================

Name: mm_io_responder

Overview:
Memory-mapped I/O responder on the CPU's external data-memory port. It serves any access whose address falls in 0xC000–0xC007. It holds an LED register, synchronized switch inputs with change detection, a prescaled 16-bit timer/compare unit with sticky status, and an interrupt output. Read data is combinational in the same cycle as mm_re, so the CPU's dst mux can capture it at the EX/DM→WB edge. Writes commit on the clock edge.

Parameters:
BASE, 13'h1800, must match addr[15:3] for the block to respond (0xC000–0xC007)
LED_W, 10, LED register width
SW_W, 10, switch input width
ID_VAL, 16'hA55A, constant returned by the ID register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
addr  in  16  byte-less word address from CPU (dst_EX_DM)
wdata  in  16  store data from CPU
mm_we  in  1  external write strobe, 1 cycle per store (may repeat under stall)
mm_re  in  1  external read strobe
rdata  out  16  read data, combinational
sw  in  SW_W  asynchronous board switches
ledr  out  LED_W  LED drive
irq  out  1  level interrupt

Behaviour:
- hit = (addr[15:3]==BASE). Accesses that miss are ignored; rdata=0 on a miss or when mm_re=0.
- Register map (index addr[2:0]):
  - 0 LED: RW. Bits [LED_W-1:0]; upper bits read 0.
  - 1 SW: RO. Synchronized switches, zero-extended. Writes are ignored.
  - 2 CNT: RW. Timer count.
  - 3 CMP: RW. Compare value.
  - 4 PRESC: RW. Prescale terminal value.
  - 5 CTRL: RW. bit0 en, bit1 auto_reload, bit2 match_ie, bit3 sw_ie; other bits read 0.
  - 6 STATUS: bit0 match, bit1 sw_chg. Write-1-to-clear; writing 0 has no effect.
  - 7 ID: RO, returns ID_VAL.
- Reads have no side effects, so repeated mm_re during a pipeline stall is safe. Repeated mm_we simply rewrites the same value.
- Reset values: ledr=0, CNT=0, CMP=16'hFFFF, PRESC=0, CTRL=0, STATUS=0, prescaler=0, sync flops=0, irq=0.
- Switch path:
  - 2-flop synchronizer, then a registered copy sw_q.
  - sw_chg is set on any cycle where sync output != sw_q.
  - SW reads return sw_q, giving 3 cycles of latency from pin to readable value.
- Prescaler:
  - Runs only while en=1.
  - Counts 0..PRESC; tick=1 in the cycle where it equals PRESC, then wraps to 0.
  - PRESC=0 gives a tick every cycle.
  - Cleared to 0 on any write to CNT, CTRL or PRESC.
- Timer, on a tick:
  - If CNT==CMP: set match. If auto_reload=1, CNT←0 and en stays 1; otherwise CNT holds and en clears (one-shot).
  - Else CNT←CNT+1, wrapping 16'hFFFF→0.
- Simultaneous events:
  - CPU write to CNT/CTRL in the same cycle as a tick: the CPU write wins and the tick is discarded.
  - Hardware set of match/sw_chg in the same cycle as a W1C of that bit: the set wins.
- irq = (match & match_ie) | (sw_chg & sw_ie), registered, so it appears 1 cycle after the status bit.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous).
- Widths: all counter arithmetic is 16-bit unsigned; no saturation.

Decomposition:
- Shared package: register index constants (REG_LED..REG_ID), CTRL/STATUS bit positions, and default ID_VAL, so CPU test programs and the bench share one map.
- One natural sub-module: mm_timer (prescaler + CNT/CMP + match logic, with load/ctrl-write inputs and a match_set output).
- Synchronizer and register file stay in the top module.

Test Plan:
- Reset, then read indices 0..7 → 0, sw_q, 0, 0xFFFF, 0, 0, 0, 0xA55A; read 0xB000 (miss) → rdata=0.
- Write LED 0xFFFF → ledr=10'h3FF and readback 0x03FF; write 0x1234 to SW → SW readback unchanged.
- PRESC=0, CMP=3, CTRL=0x3:
  - CNT reads 1, 2, 3 on the next cycles.
  - match sets on the 4th tick edge, CNT→0.
  - Write STATUS=1 clears match; it re-sets 4 ticks later.
- PRESC=2, CMP=1, CTRL=0x5 (one-shot, ie):
  - CNT increments every 3 cycles.
  - On the match tick, en clears and CNT holds at 1.
  - irq rises 1 cycle after match.
  - W1C drops irq the following cycle.
- Toggle sw[0] with CTRL=0x8 → SW read shows the new value 3 cycles later; sw_chg=1; irq=1. Write STATUS=2 while sw still toggling → set wins, sw_chg stays 1.
- Write CNT=0x0005 in a tick cycle with CTRL=0x3 → CNT reads 5, not 6. Assert rst_n low mid-count → all outputs 0 immediately.

Source files
------------

// File: rtl/mm_io_responder_pkg.sv
// mm_io_responder_pkg: shared register map, bit positions and defaults for the MMIO responder
package mm_io_responder_pkg;

    localparam logic [12:0] BASE_DEF = 13'h1800;
    localparam logic [15:0] ID_DEF   = 16'hA55A;

    typedef enum logic [2:0] {
        REG_LED    = 3'd0,
        REG_SW     = 3'd1,
        REG_CNT    = 3'd2,
        REG_CMP    = 3'd3,
        REG_PRESC  = 3'd4,
        REG_CTRL   = 3'd5,
        REG_STATUS = 3'd6,
        REG_ID     = 3'd7
    } reg_idx_e;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AR    = 1;
    localparam int CTRL_MIE   = 2;
    localparam int CTRL_SIE   = 3;
    localparam int STAT_MATCH = 0;
    localparam int STAT_SWCHG = 1;

    function automatic logic addr_hit(input logic [15:0] a, input logic [12:0] base);
        return a[15:3] == base;
    endfunction

endpackage

// File: rtl/mm_io_responder_timer.sv
// mm_io_responder_timer: prescaled 16-bit up-counter with compare, one-shot/auto-reload and match pulse
module mm_io_responder_timer
    import mm_io_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_wdata,
    input  logic        i_cnt_we,
    input  logic        i_cmp_we,
    input  logic        i_presc_we,
    input  logic        i_ctrl_we,
    output logic [15:0] o_cnt,
    output logic [15:0] o_cmp,
    output logic [15:0] o_presc,
    output logic        o_en,
    output logic        o_ar,
    output logic        o_match_set
);

    logic [15:0] r_cnt, r_cmp, r_presc, r_pcnt;
    logic        r_en, r_ar;
    logic        w_tick, w_eq, w_cpu_wins;

    assign w_tick      = r_en && (r_pcnt == r_presc);
    assign w_eq        = r_cnt == r_cmp;
    assign w_cpu_wins  = i_cnt_we | i_ctrl_we;
    assign o_match_set = w_tick && w_eq && !w_cpu_wins;
    assign o_cnt       = r_cnt;
    assign o_cmp       = r_cmp;
    assign o_presc     = r_presc;
    assign o_en        = r_en;
    assign o_ar        = r_ar;

    // Prescaler: restarts on any reconfiguration so the first tick is a full period away
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pcnt <= '0;
        else if (i_cnt_we | i_ctrl_we | i_presc_we)
            r_pcnt <= '0;
        else if (r_en)
            r_pcnt <= w_tick ? 16'd0 : r_pcnt + 16'd1;
    end

    // Timer state: CPU writes to CNT/CTRL override a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_cmp   <= 16'hFFFF;
            r_presc <= '0;
            r_en    <= 1'b0;
            r_ar    <= 1'b0;
        end else begin
            if (i_cmp_we)
                r_cmp <= i_wdata;
            if (i_presc_we)
                r_presc <= i_wdata;
            if (i_cnt_we)
                r_cnt <= i_wdata;
            else if (w_tick && !i_ctrl_we)
                r_cnt <= w_eq ? (r_ar ? 16'd0 : r_cnt) : r_cnt + 16'd1;
            if (i_ctrl_we) begin
                r_en <= i_wdata[CTRL_EN];
                r_ar <= i_wdata[CTRL_AR];
            end else if (o_match_set && !r_ar)
                r_en <= 1'b0;
        end
    end

endmodule

// File: rtl/mm_io_responder.sv
// mm_io_responder: memory-mapped LED/switch/timer/interrupt block at 0xC000-0xC007
module mm_io_responder
    import mm_io_responder_pkg::*;
#(
    parameter logic [12:0] BASE   = BASE_DEF,
    parameter int          LED_W  = 10,
    parameter int          SW_W   = 10,
    parameter logic [15:0] ID_VAL = ID_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      addr,
    input  logic [15:0]      wdata,
    input  logic             mm_we,
    input  logic             mm_re,
    output logic [15:0]      rdata,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] ledr,
    output logic             irq
);

    logic [LED_W-1:0] r_led;
    logic [SW_W-1:0]  r_sync1, r_sync2, r_sw_q;
    logic             r_mie, r_sie, r_match, r_swchg, r_irq;
    logic             w_hit, w_wr;
    reg_idx_e         w_idx;
    logic [15:0]      w_cnt, w_cmp, w_presc;
    logic             w_en, w_ar, w_match_set, w_swchg_set, w_st_we;

    assign w_hit       = addr_hit(addr, BASE);
    assign w_idx       = reg_idx_e'(addr[2:0]);
    assign w_wr        = w_hit && mm_we;
    assign w_st_we     = w_wr && w_idx == REG_STATUS;
    assign w_swchg_set = r_sync2 != r_sw_q;
    assign ledr        = r_led;
    assign irq         = r_irq;

    mm_io_responder_timer u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wdata     (wdata),
        .i_cnt_we    (w_wr && w_idx == REG_CNT),
        .i_cmp_we    (w_wr && w_idx == REG_CMP),
        .i_presc_we  (w_wr && w_idx == REG_PRESC),
        .i_ctrl_we   (w_wr && w_idx == REG_CTRL),
        .o_cnt       (w_cnt),
        .o_cmp       (w_cmp),
        .o_presc     (w_presc),
        .o_en        (w_en),
        .o_ar        (w_ar),
        .o_match_set (w_match_set)
    );

    // Two-flop synchronizer plus a registered copy used for reads and change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sw_q  <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            r_sw_q  <= r_sync2;
        end
    end

    // CPU-writable registers; status bits are W1C with hardware set taking priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led   <= '0;
            r_mie   <= 1'b0;
            r_sie   <= 1'b0;
            r_match <= 1'b0;
            r_swchg <= 1'b0;
        end else begin
            if (w_wr && w_idx == REG_LED)
                r_led <= wdata[LED_W-1:0];
            if (w_wr && w_idx == REG_CTRL) begin
                r_mie <= wdata[CTRL_MIE];
                r_sie <= wdata[CTRL_SIE];
            end
            r_match <= w_match_set | (r_match & ~(w_st_we & wdata[STAT_MATCH]));
            r_swchg <= w_swchg_set | (r_swchg & ~(w_st_we & wdata[STAT_SWCHG]));
        end
    end

    // Interrupt is registered, trailing the status bits by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_irq <= 1'b0;
        else
            r_irq <= (r_match & r_mie) | (r_swchg & r_sie);
    end

    // Side-effect-free combinational read mux
    always_comb begin
        rdata = '0;
        if (w_hit && mm_re)
            case (w_idx)
                REG_LED:    rdata = 16'(r_led);
                REG_SW:     rdata = 16'(r_sw_q);
                REG_CNT:    rdata = w_cnt;
                REG_CMP:    rdata = w_cmp;
                REG_PRESC:  rdata = w_presc;
                REG_CTRL:   rdata = {12'd0, r_sie, r_mie, w_ar, w_en};
                REG_STATUS: rdata = {14'd0, r_swchg, r_match};
                REG_ID:     rdata = ID_VAL;
                default:    rdata = '0;
            endcase
    end

endmodule

// File: tb/tb_mm_io_responder.sv
// tb_mm_io_responder: scoreboard-driven check of register map, timer, switch path, irq and reset
module tb_mm_io_responder;
    import mm_io_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        mm_we = 1'b0;
    logic        mm_re = 1'b0;
    logic [15:0] rdata;
    logic [9:0]  sw = '0;
    logic [9:0]  ledr;
    logic        irq;

    int          total = 0;
    int          bad = 0;
    logic [15:0] sb_q[$];

    mm_io_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .wdata (wdata),
        .mm_we (mm_we),
        .mm_re (mm_re),
        .rdata (rdata),
        .sw    (sw),
        .ledr  (ledr),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All tasks start and end at a negedge
    task automatic wr(input logic [2:0] idx, input logic [15:0] d);
        addr  = {13'h1800, idx};
        wdata = d;
        mm_we = 1'b1;
        @(negedge clk);
        mm_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        sb_q.push_back(exp);
        addr  = a;
        mm_re = 1'b1;
        #1;
        chk(tag, rdata, sb_q.pop_front());
        mm_re = 1'b0;
    endtask

    function automatic logic [15:0] ra(input logic [2:0] idx);
        return {13'h1800, idx};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [15:0] rst_exp [8];
        rst_exp = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hA55A};
        idle(2);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++)
            rd($sformatf("reset_reg%0d", i), ra(3'(i)), rst_exp[i]);
        rd("miss_read", 16'hB000, 16'h0000);
        addr = ra(REG_ID);
        #1;
        chk("no_re_zero", rdata, 16'h0000);
        chk("reset_irq", {15'd0, irq}, 16'h0000);

        wr(REG_LED, 16'hFFFF);
        chk("ledr_pins", {6'd0, ledr}, 16'h03FF);
        rd("led_readback", ra(REG_LED), 16'h03FF);
        wr(REG_SW, 16'h1234);
        rd("sw_ro", ra(REG_SW), 16'h0000);

        wr(REG_PRESC, 16'd0);
        wr(REG_CMP, 16'd3);
        wr(REG_CTRL, 16'h0003);
        rd("ar_cnt0", ra(REG_CNT), 16'd0);
        for (int i = 1; i <= 3; i++) begin
            idle(1);
            rd($sformatf("ar_cnt%0d", i), ra(REG_CNT), 16'(i));
            rd("ar_nomatch", ra(REG_STATUS), 16'd0);
        end
        idle(1);
        rd("ar_wrap", ra(REG_CNT), 16'd0);
        rd("ar_match", ra(REG_STATUS), 16'd1);
        rd("ar_en_kept", ra(REG_CTRL), 16'h0003);
        wr(REG_STATUS, 16'h0001);
        rd("ar_w1c", ra(REG_STATUS), 16'd0);
        idle(2);
        rd("ar_not_yet", ra(REG_STATUS), 16'd0);
        idle(1);
        rd("ar_reset", ra(REG_STATUS), 16'd1);

        wr(REG_CTRL, 16'h0000);
        wr(REG_STATUS, 16'h0001);
        wr(REG_CNT, 16'd0);
        wr(REG_PRESC, 16'd2);
        wr(REG_CMP, 16'd1);
        wr(REG_CTRL, 16'h0005);
        idle(2);
        rd("os_hold0", ra(REG_CNT), 16'd0);
        idle(1);
        rd("os_cnt1", ra(REG_CNT), 16'd1);
        idle(2);
        rd("os_nomatch", ra(REG_STATUS), 16'd0);
        idle(1);
        rd("os_match", ra(REG_STATUS), 16'd1);
        rd("os_cnt_hold", ra(REG_CNT), 16'd1);
        rd("os_en_clr", ra(REG_CTRL), 16'h0004);
        chk("os_irq_lag", {15'd0, irq}, 16'd0);
        idle(1);
        chk("os_irq_up", {15'd0, irq}, 16'd1);
        idle(3);
        rd("os_stopped", ra(REG_CNT), 16'd1);
        wr(REG_STATUS, 16'h0001);
        chk("os_irq_w1c_lag", {15'd0, irq}, 16'd1);
        idle(1);
        chk("os_irq_down", {15'd0, irq}, 16'd0);

        wr(REG_CTRL, 16'h0008);
        sw = 10'h001;
        idle(2);
        rd("sw_lat2", ra(REG_SW), 16'h0000);
        idle(1);
        rd("sw_lat3", ra(REG_SW), 16'h0001);
        rd("sw_chg", ra(REG_STATUS), 16'h0002);
        idle(1);
        chk("sw_irq", {15'd0, irq}, 16'd1);
        sw = 10'h000;
        idle(2);
        wr(REG_STATUS, 16'h0002);
        rd("sw_set_wins", ra(REG_STATUS), 16'h0002);
        wr(REG_STATUS, 16'h0002);
        rd("sw_clear", ra(REG_STATUS), 16'h0000);
        idle(1);
        chk("sw_irq_down", {15'd0, irq}, 16'd0);

        wr(REG_CTRL, 16'h0000);
        wr(REG_PRESC, 16'd0);
        wr(REG_CNT, 16'd0);
        wr(REG_CMP, 16'hFFFF);
        wr(REG_CTRL, 16'h0003);
        idle(1);
        rd("race_pre", ra(REG_CNT), 16'd1);
        wr(REG_CNT, 16'd5);
        rd("race_cnt_wins", ra(REG_CNT), 16'd5);
        idle(1);
        rd("race_after", ra(REG_CNT), 16'd6);
        wr(REG_CTRL, 16'h0003);
        rd("race_ctrl_wins", ra(REG_CNT), 16'd6);

        wr(REG_LED, 16'h02A5);
        idle(3);
        rst_n = 1'b0;
        #1;
        chk("rst_ledr", {6'd0, ledr}, 16'h0000);
        chk("rst_irq", {15'd0, irq}, 16'h0000);
        rd("rst_cnt", ra(REG_CNT), 16'h0000);
        rd("rst_ctrl", ra(REG_CTRL), 16'h0000);
        rd("rst_cmp", ra(REG_CMP), 16'hFFFF);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
